uart_bus_arbiter: RTL
=====================

Name: uart_bus_arbiter

Overview:
- Shares the single UART TX/RX pair and the checksum checker among N_REQ requesters using round-robin arbitration.
- Each transaction runs in order:
  - send one command byte;
  - wait for TX completion;
  - wait for one response byte;
  - validate it with the external checksum result;
  - retry on error or timeout;
  - return the response byte to the granted requester.
- Sits between the requester logic and the existing control/UART/CRC datapath.
- Exports the same 2-bit status encoding used by the bus control logic.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 52080, clocks allowed in WAIT_RX before a timeout (10 bit-times at 5208 clocks/bit).
- MAX_RETRY, 2, retries after the first attempt before reporting an error.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  N_REQ  request lines; held high until the matching done bit.
- req_data  in  8*N_REQ  command bytes; requester i occupies [8i+7:8i].
- grant  out  N_REQ  one-hot current owner; all zeros when idle.
- done  out  N_REQ  one-cycle completion pulse to the owner.
- resp_data  out  8  response byte; valid in the done cycle, held until the next transaction.
- resp_err  out  1  valid with done; 1 = retries exhausted.
- tx_data  out  8  byte to UART TX.
- tx_enable  out  1  one-cycle start pulse to UART TX.
- tx_active  in  1  UART TX busy.
- tx_done  in  1  UART TX finished; one-cycle pulse.
- rx_data  in  8  UART RX byte.
- rx_done  in  1  UART RX byte valid; one-cycle pulse.
- checksum_ok  in  1  checker verdict; valid in the rx_done cycle.
- status  out  2  0 = waiting transmission, 1 = waiting reception, 2 = response OK, 3 = CRC/timeout error.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; all outputs 0.
  - RR pointer = N_REQ-1, so requester 0 wins first; retry counter = 0; timeout counter = 0.
- IDLE → ARB: when any req bit is high.
- ARB (1 cycle):
  - Select the first set req bit searching ptr+1, ptr+2, … modulo N_REQ.
  - Register grant one-hot.
  - Latch that requester's req_data into an internal command register.
  - → SEND.
- SEND:
  - Wait while tx_active = 1.
  - When tx_active = 0: drive tx_data = command, pulse tx_enable for exactly 1 cycle → WAIT_TX.
  - status = 0.
- WAIT_TX:
  - On tx_done: clear the timeout counter → WAIT_RX.
  - No timeout in this state.
- WAIT_RX (status = 1):
  - Timeout counter increments every cycle.
  - rx_done with checksum_ok = 1: latch rx_data into resp_data, resp_err = 0 → RESP.
  - rx_done with checksum_ok = 0, or counter reaching TIMEOUT-1 without rx_done, is a failure:
    - if retry < MAX_RETRY: retry++ → SEND (the same latched command is resent);
    - otherwise: resp_err = 1, resp_data = last rx byte (0 on timeout) → RESP.
  - rx_done and timeout in the same cycle: rx_done wins.
- RESP (1 cycle):
  - done[owner] = 1; status = 2 (ok) or 3 (error).
  - ptr = owner; retry = 0.
  - grant cleared on the next edge → IDLE.
- status holds 2/3 in IDLE until the next ARB.
- Latency: ARB to tx_enable is 2 cycles if TX is idle.
- req dropping mid-transaction is ignored; the transaction completes and done still pulses. req_data changes after ARB are ignored.
- A requester that keeps req high after done is re-arbitrated behind the others. A lone requester is re-granted back to back, with 1 IDLE cycle in between.
- Stray tx_done outside WAIT_TX and stray rx_done outside WAIT_RX are ignored.
- Reset asserted mid-transaction aborts it immediately: no done pulse and no tx_enable.

Optional Feature:
- Macro ARB_PRIO0_EN.
- Defined: requester 0 has fixed highest priority. If req[0] is set in ARB, it wins regardless of ptr. Other requesters use round robin, and ptr is updated only by non-zero owners.
- Undefined: pure round robin for all requesters.

Test Plan:
- Single transaction: req = 4'b0100, req_data[23:16] = 8'hAA → grant = 4'b0100, tx_enable one pulse with tx_data = 8'hAA; after tx_done, status = 1; rx_done with rx_data = 8'h55, checksum_ok = 1 → done = 4'b0100 for 1 cycle, resp_data = 8'h55, resp_err = 0, status = 2.
- Round robin: req = 4'b1111 held → grants in order 0, 1, 2, 3, 0; each done precedes the next grant.
- CRC retry: checksum_ok = 0 on the first two rx_done, 1 on the third → 3 tx_enable pulses all carrying the same byte, resp_err = 0. With checksum_ok = 0 three times → resp_err = 1, status = 3.
- Timeout: no rx_done after tx_done → tx_enable repeats every TIMEOUT cycles, 3 attempts in total, then done with resp_err = 1, resp_data = 8'h00. rx_done in the exact timeout cycle → accepted, no retry.
- TX busy and reset: tx_active held high for 100 cycles → tx_enable delayed until it falls. reset pulsed low during WAIT_RX → grant = 0, status = 0 immediately, no done pulse.
- ARB_PRIO0_EN: with the macro defined, req = 4'b1010 then req[0] raised during the first transaction → requester 0 is granted next, ahead of 3.

Source files
------------

// File: rtl/uart_bus_arbiter.sv
// Round-robin owner of the shared UART TX/RX pair and checksum checker; resends the command on CRC error or RX timeout.
// Latency: ARB to tx_enable is 2 cycles with TX idle; done pulses one cycle after the accepted or final response.
// Backpressure: stalls in SEND while tx_active; req is level-held until done. ARB_PRIO0_EN gives requester 0 fixed priority.
module uart_bus_arbiter #(
    parameter int N_REQ     = 4,
    parameter int TIMEOUT   = 52080,
    parameter int MAX_RETRY = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [7:0]           resp_data,
    output logic                 resp_err,
    output logic [7:0]           tx_data,
    output logic                 tx_enable,
    input  logic                 tx_active,
    input  logic                 tx_done,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    input  logic                 checksum_ok,
    output logic [1:0]           status
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_SEND, S_WAIT_TX, S_WAIT_RX, S_RESP
    } state_t;

    state_t         state_q, state_d;
    logic [PW-1:0]  ptr_q, owner_q, sel_idx, cand;
    logic           sel_vld;
    logic [7:0]     cmd_q;
    logic [RW-1:0]  retry_q;
    logic [TW-1:0]  tmo_q;
    logic [1:0]     last_status_q;
    logic           rx_ok, attempt_fail, retry_left;

    assign rx_ok        = rx_done && checksum_ok;
    assign attempt_fail = (rx_done && !checksum_ok) || (!rx_done && tmo_q == TW'(TIMEOUT - 1));
    assign retry_left   = retry_q < RW'(MAX_RETRY);
    assign done         = (state_q == S_RESP) ? grant : '0;

    // Search starts one past the last owner so the previous winner goes to the back.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % N_REQ);
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
`ifdef ARB_PRIO0_EN
        if (req[0]) begin
            sel_vld = 1'b1;
            sel_idx = '0;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        status  = 2'd0;
        case (state_q)
            S_IDLE: begin
                status = last_status_q;
                if (|req) state_d = S_ARB;
            end
            S_ARB:     state_d = sel_vld ? S_SEND : S_IDLE;
            S_SEND:    if (!tx_active) state_d = S_WAIT_TX;
            S_WAIT_TX: if (tx_done) state_d = S_WAIT_RX;
            S_WAIT_RX: begin
                status = 2'd1;
                if (rx_ok)             state_d = S_RESP;
                else if (attempt_fail) state_d = retry_left ? S_SEND : S_RESP;
            end
            S_RESP: begin
                status  = {1'b1, resp_err};
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q         <= PW'(N_REQ - 1);
            owner_q       <= '0;
            grant         <= '0;
            cmd_q         <= '0;
            retry_q       <= '0;
            tmo_q         <= '0;
            tx_enable     <= 1'b0;
            tx_data       <= '0;
            resp_data     <= '0;
            resp_err      <= 1'b0;
            last_status_q <= 2'd0;
        end else begin
            tx_enable <= 1'b0;
            case (state_q)
                S_ARB: if (sel_vld) begin
                    grant   <= N_REQ'(1) << sel_idx;
                    owner_q <= sel_idx;
                    cmd_q   <= req_data[8*sel_idx +: 8];
                end
                S_SEND: if (!tx_active) begin
                    tx_enable <= 1'b1;
                    tx_data   <= cmd_q;
                end
                S_WAIT_TX: if (tx_done) tmo_q <= '0;
                S_WAIT_RX: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (rx_ok) begin
                        resp_data <= rx_data;
                        resp_err  <= 1'b0;
                    end else if (attempt_fail) begin
                        if (retry_left) begin
                            retry_q <= retry_q + 1'b1;
                        end else begin
                            resp_err  <= 1'b1;
                            resp_data <= rx_done ? rx_data : 8'h00;
                        end
                    end
                end
                S_RESP: begin
                    grant         <= '0;
                    retry_q       <= '0;
                    last_status_q <= {1'b1, resp_err};
`ifdef ARB_PRIO0_EN
                    // Requester 0 wins by priority, so it must not disturb the rotation.
                    if (owner_q != '0) ptr_q <= owner_q;
`else
                    ptr_q <= owner_q;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule
